// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with an internal write FIFO.
// Words pushed with send are queued and sent back-to-back as
// start / DATA_BITS payload (LSB first) / optional parity / STOP_BITS stop.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   block - inhibits the start of new frames (current frame completes)
//   send  - write strobe, data is queued when full = 0
//   data  - word to queue
//   busy  - frame in progress or FIFO non-empty (registered)
//   full  - FIFO holds FIFO_DEPTH words (registered)
//   tx    - serial line, idles high (registered)
module uart_tx_fifo #(
  parameter int unsigned CLK_PER_BIT = 434,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 block,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 full,
  output logic                 tx
);

  localparam int unsigned CCW = $clog2(CLK_PER_BIT);
  localparam int unsigned BCW = $clog2(DATA_BITS);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;

  localparam logic [CCW-1:0] CLK_LAST  = CCW'(CLK_PER_BIT - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic [PW-1:0]  FULL_XOR  = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CCW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 tick;
  logic                 can_start;
  logic [DATA_BITS-1:0] head;
  logic                 tx_d;
  logic                 busy_d;
  logic                 full_d;

  // FIFO status; full is the registered flag, so a push is judged before any pop
  always_comb begin
    empty     = (wptr_q == rptr_q);
    push      = send && !full;
    head      = mem[rptr_q[AW-1:0]];
    tick      = (clk_cnt_q == CLK_LAST);
    can_start = !empty && !block;
  end

  // Write port of the FIFO storage; contents are don't-care once flushed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q[AW-1:0]] <= data;
    end
  end

  // Next-state, counters, shift register and pop control
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    pop       = 1'b0;

    // Bit-period counter runs in every state except IDLE
    if (state_q != S_IDLE) begin
      clk_cnt_d = tick ? '0 : clk_cnt_q + CCW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            if (can_start) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Popping loads the FIFO head and precomputes its parity bit
    if (pop) begin
      clk_cnt_d = '0;
      shreg_d   = head;
      par_d     = (PARITY == 1) ? ~^head : ^head;
    end
  end

  // Pointer update and registered output values
  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) || (wptr_d != rptr_d);
    full_d = ((wptr_d ^ rptr_d) == FULL_XOR);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      full      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      tx        <= tx_d;
      busy      <= busy_d;
      full      <= full_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: three configurations (8N1, 8E2, 8O1) share the
// same stimulus; each is compared every cycle against a frame-level model
// that treats a frame as a list of bits each lasting CLK_PER_BIT cycles.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       block;
  logic       send;
  logic [7:0] data;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] full_v;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .block(block), .send(send), .data(data),
    .busy(busy_v[0]), .full(full_v[0]), .tx(tx_v[0]));

  uart_tx_fifo #(.CLK_PER_BIT(3), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .block(block), .send(send), .data(data),
    .busy(busy_v[1]), .full(full_v[1]), .tx(tx_v[1]));

  uart_tx_fifo #(.CLK_PER_BIT(5), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .block(block), .send(send), .data(data),
    .busy(busy_v[2]), .full(full_v[2]), .tx(tx_v[2]));

  function automatic int cpb_of(int i);
    case (i)
      0:       return 4;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic int par_of(int i);
    case (i)
      0:       return 0;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int stop_of(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int frame_cycles(int i);
    return (1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i)) * cpb_of(i);
  endfunction

  // Bit idx of the frame carrying word w
  function automatic logic frame_bit(int i, logic [7:0] w, int idx);
    int ones;
    ones = $countones(w);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (par_of(i) != 0 && idx == 9) begin
      if (par_of(i) == 1) return (ones % 2 == 0) ? 1'b1 : 1'b0;
      return (ones % 2 == 1) ? 1'b1 : 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model state per instance
  int         m_cnt [3];
  logic [7:0] m_fifo[3][4];
  bit         m_inf [3];
  int         m_cyc [3];
  logic [7:0] m_cur [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_inf[i] = 1'b0;
      m_cyc[i] = 0;
    end
  endtask

  // One clock edge of the model, using the inputs held across the edge
  task automatic model_edge();
    bit can_push;
    bit nonempty;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      can_push = send && (m_cnt[i] < 4);
      nonempty = (m_cnt[i] > 0);
      if (m_inf[i]) begin
        m_cyc[i]++;
        if (m_cyc[i] == frame_cycles(i)) m_inf[i] = 1'b0;
      end
      if (!m_inf[i] && nonempty && !block) begin
        m_cur[i] = m_fifo[i][0];
        for (int k = 0; k < 3; k++) m_fifo[i][k] = m_fifo[i][k+1];
        m_cnt[i]--;
        m_inf[i] = 1'b1;
        m_cyc[i] = 0;
      end
      if (can_push) begin
        m_fifo[i][m_cnt[i]] = data;
        m_cnt[i]++;
      end
    end
  endtask

  task automatic check_all();
    logic exp_tx, exp_busy, exp_full;
    for (int i = 0; i < 3; i++) begin
      exp_tx   = m_inf[i] ? frame_bit(i, m_cur[i], m_cyc[i] / cpb_of(i)) : 1'b1;
      exp_busy = m_inf[i] || (m_cnt[i] > 0);
      exp_full = (m_cnt[i] == 4);
      checks++;
      assert (tx_v[i] === exp_tx) else begin
        errors++;
        $error("FAIL tx%0d t=%0t observed %b expected %b", i, $time, tx_v[i], exp_tx);
      end
      checks++;
      assert (busy_v[i] === exp_busy) else begin
        errors++;
        $error("FAIL busy%0d t=%0t observed %b expected %b", i, $time, busy_v[i], exp_busy);
      end
      checks++;
      assert (full_v[i] === exp_full) else begin
        errors++;
        $error("FAIL full%0d t=%0t observed %b expected %b", i, $time, full_v[i], exp_full);
      end
    end
  endtask

  // Inputs change at negedge; model steps on posedge; outputs checked at negedge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic drain(int maxc);
    int k;
    k = 0;
    while (busy_v !== 3'b000 && k < maxc) begin
      cycle();
      k++;
    end
    checks++;
    assert (busy_v === 3'b000) else begin
      errors++;
      $error("FAIL drain_timeout observed busy %b expected 000", busy_v);
    end
  endtask

  initial begin
    rst   = 1'b1;
    block = 1'b0;
    send  = 1'b0;
    data  = 8'h00;
    model_reset();
    run(2);
    rst = 1'b0;
    run(3);

    // Single frame of 8'h4F
    data = 8'h4F;
    send = 1'b1;
    cycle();
    send = 1'b0;
    drain(300);
    run(2);

    // Five writes while blocked: fifth dropped, then four back-to-back frames
    block = 1'b1;
    for (int n = 0; n < 5; n++) begin
      data = 8'($urandom);
      send = 1'b1;
      cycle();
    end
    send = 1'b0;
    run(3);
    block = 1'b0;
    drain(600);

    // Block raised mid-frame with a second word queued, then released
    data = 8'($urandom);
    send = 1'b1;
    cycle();
    data = 8'($urandom);
    cycle();
    send = 1'b0;
    run(15);
    block = 1'b1;
    run(80);
    block = 1'b0;
    drain(300);

    // Reset in the middle of the data bits, with more words queued
    for (int n = 0; n < 3; n++) begin
      data = 8'($urandom);
      send = 1'b1;
      cycle();
    end
    send = 1'b0;
    run(10);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
    run(60);

    // Randomised traffic with occasional block toggles
    for (int n = 0; n < 800; n++) begin
      send = ($urandom_range(0, 2) == 0);
      data = 8'($urandom);
      if ($urandom_range(0, 39) == 0) block = ~block;
      cycle();
    end
    send  = 1'b0;
    block = 1'b0;
    drain(800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter and successor to the fixed 8N1 byte transmitter. It adds configurable data width, parity mode and stop-bit count, plus an internal write FIFO so that several words can be queued and sent back-to-back. It sits between on-chip producers (debug/telemetry logic) and the board-level serial TX pin. It keeps the existing `block`/`send`/`busy` handshake so current callers can be ported with a parameter change only.

## Interface
Parameters:
- `CLK_PER_BIT`, 434: clock cycles per serial bit (434 gives 115200 baud at 50 MHz); legal range ≥ 2.
- `DATA_BITS`, 8: payload bits per frame; legal range 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, 4: word capacity of the write FIFO; must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset, asynchronous and active-high.
- `block`  in  1  when high, no new frame is started; a frame already in progress completes.
- `send`  in  1  write strobe; `data` is pushed into the FIFO on a rising edge where `send` = 1 and `full` = 0.
- `data`  in  DATA_BITS  word to queue.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `full`  out  1  FIFO holds FIFO_DEPTH words.
- `tx`  out  1  serial line; idles high.

## Operation
- FSM states and transitions:
  - IDLE → START when the FIFO is non-empty and `block` = 0. The FIFO head is popped into the shift register on that edge.
  - START → DATA.
  - DATA → PARITY when PARITY ≠ 0, otherwise → STOP.
  - PARITY → STOP.
  - STOP → START when the FIFO is non-empty and `block` = 0; otherwise → IDLE.
- Each state other than IDLE lasts exactly CLK_PER_BIT cycles, measured by a clock counter of width $clog2(CLK_PER_BIT).
- DATA shifts the word out LSB first, with a bit counter running from 0 to DATA_BITS−1. STOP holds `tx` high for STOP_BITS bit periods.
- Parity bit:
  - odd mode: XNOR-reduce of the payload, so the total count of ones including the parity bit is odd.
  - even mode: XOR-reduce of the payload.
- `tx` levels by state: 1 in IDLE and STOP, 0 in START, payload bit in DATA, parity bit in PARITY. `tx` is registered, so it is glitch-free.
- FIFO: circular buffer with read/write pointers one bit wider than needed for addressing.
  - Empty when the pointers are equal.
  - Full when the pointers differ only in the MSB.
  - Pointers wrap naturally.
- `send` while `full` = 1 is dropped silently. This holds even when a pop happens on the same edge, because `full` is evaluated before the pop.
- Reset: the FIFO is flushed, the FSM goes to IDLE and the counters clear. Outputs take `tx` = 1, `busy` = 0, `full` = 0 immediately (asynchronously). Reset asserted mid-frame truncates the frame, and the line returns high at once.

## Timing
- Start latency:
  - `send` is sampled high at edge N, with the FSM in IDLE and `block` = 0.
  - `busy` = 1 after edge N.
  - At edge N+1 the word is popped and `tx` falls to 0.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_PER_BIT cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle. There is no idle gap.
- `busy` falls on the edge that ends the last stop bit, when the FIFO is empty (STOP → IDLE).
- `full` updates on the edge of the write or pop that changes the count.
- Raising `block` during a frame has no effect until the STOP → next transition. The FSM then enters IDLE; `busy` stays 1 if words remain queued.
- Lowering `block` with a non-empty FIFO in IDLE: the start bit begins on the following edge.
- `data` is captured on the write edge; later changes to `data` do not affect queued words.

## Test plan
- Defaults (8N1, CLK_PER_BIT = 434, 20 ns clock), send 8'h4F with `block` = 0:
  - `tx` sequence is 0,1,1,1,1,0,0,1,0,1, each bit 434 cycles, 4340 cycles in total.
  - `tx` falls 1 cycle after the `send` edge.
  - `busy` drops at the end of the stop bit.
- PARITY = 2, then PARITY = 1, send 8'h4F: parity bit is 1 for even and 0 for odd. The frame is 11 bits (4774 cycles).
- DATA_BITS = 7, STOP_BITS = 2, send 7'h55: sequence is 0,1,0,1,0,1,0,1,1,1. The frame is 10 bits, with two stop bits.
- FIFO_DEPTH = 4, `block` = 1, send 5 words on consecutive cycles:
  - `full` = 1 after the 4th write; the 5th word is dropped.
  - `block` is then released: 4 frames go out with no gap between stop and start bits.
  - `busy` = 0 only after the 4th frame.
- Raise `block` mid-frame with 2 words queued: the current frame completes, `tx` stays high, and `busy` stays 1. Release `block` and the next start bit appears on the following edge.
- Assert `rst` midway through the data bits: `tx` = 1, `busy` = 0 and `full` = 0 immediately. After release, nothing is transmitted until a new `send`.
